logic_unit: RTL and testbench

LOGIC_UNIT -- requirements
Module: logic_unit

---
 rtl/logic_unit.sv | 129 ++++++++++++
 tb/tb_logic_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit.sv
// logic_unit: bitwise logic ops on single beats plus AND/OR accumulation
// across multi-beat bursts, with a single registered output stage under
// valid/ready handshaking.
module logic_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_all,
  output logic             out_any,
  output logic             out_last,
  output logic [CW-1:0]    out_count
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_acc_or;
  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_q;
  logic             r_out_last;
  logic [CW-1:0]    r_out_count;

  logic             w_accept;
  logic             w_is_acc_op;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_acc_next;
  logic [CW-1:0]    w_count_inc;

  // Handshake: accept whenever the output slot is free or being drained; never in reset.
  assign in_ready    = rst_n && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_is_acc_op = (in_op[2:1] == 2'b11);
  assign w_acc_next  = r_acc_or ? (r_acc | in_a) : (r_acc & in_a);
  assign w_count_inc = (r_count == CNT_MAX) ? CNT_MAX : (r_count + CNT_ONE);

  // Single-beat bitwise result for opcodes 0-5.
  always_comb begin
    w_logic = '0;
    case (in_op)
      3'd0:    w_logic = in_a & in_b;
      3'd1:    w_logic = in_a | in_b;
      3'd2:    w_logic = in_a ^ in_b;
      3'd3:    w_logic = ~(in_a & in_b);
      3'd4:    w_logic = ~(in_a | in_b);
      3'd5:    w_logic = ~(in_a ^ in_b);
      default: w_logic = '0;
    endcase
  end

  // Burst FSM, accumulator and output register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_acc_or    <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
      r_out_last  <= 1'b0;
      r_out_count <= '0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (!w_is_acc_op) begin
              r_out_valid <= 1'b1;
              r_out_q     <= w_logic;
              r_out_last  <= in_last;
              r_out_count <= CNT_ONE;
            end else if (in_last) begin
              r_out_valid <= 1'b1;
              r_out_q     <= in_a;
              r_out_last  <= 1'b1;
              r_out_count <= CNT_ONE;
            end else begin
              r_acc    <= in_a;
              r_acc_or <= in_op[0];
              r_count  <= CNT_ONE;
              r_state  <= S_ACC;
            end
          end
          S_ACC: begin
            if (in_last) begin
              r_out_valid <= 1'b1;
              r_out_q     <= w_acc_next;
              r_out_last  <= 1'b1;
              r_out_count <= w_count_inc;
              r_state     <= S_IDLE;
            end else begin
              r_acc   <= w_acc_next;
              r_count <= w_count_inc;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;
  assign out_last  = r_out_last;
  assign out_count = r_out_count;
  assign out_all   = &r_out_q;
  assign out_any   = |r_out_q;

endmodule

// File: tb/tb_logic_unit.sv
// Testbench for logic_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based burst model.
module tb_logic_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic             out_all;
  logic             out_any;
  logic             out_last;
  logic [CW-1:0]    out_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic_unit #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_all(out_all), .out_any(out_any),
    .out_last(out_last), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output slot plus the list of operands of the open burst.
  bit               m_known = 1'b0;
  bit               m_valid;
  logic [WIDTH-1:0] m_q;
  bit               m_last;
  int               m_cnt;
  bit               m_acc_or;
  logic [WIDTH-1:0] m_burst[$];
  logic             exp_ready;

  function automatic logic [WIDTH-1:0] bitop(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model over the coming edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] r;
    exp_ready = rst_n && (!m_valid || out_ready);
    if (m_known) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_q", 32'(out_q), 32'(m_q));
        chk("out_all", 32'(out_all), 32'(m_q == 8'hFF));
        chk("out_any", 32'(out_any), 32'(m_q != 8'h00));
        chk("out_last", 32'(out_last), 32'(m_last));
        chk("out_count", 32'(out_count), 32'(m_cnt));
      end
    end
    if (!rst_n) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_q     = '0;
      m_last  = 1'b0;
      m_cnt   = 0;
      m_burst.delete();
    end else if (m_known) begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (in_valid && exp_ready) begin
        if (m_burst.size() == 0 && in_op < 3'd6) begin
          m_valid = 1'b1; m_q = bitop(in_op, in_a, in_b); m_last = in_last; m_cnt = 1;
        end else begin
          if (m_burst.size() == 0) m_acc_or = (in_op == 3'd7);
          m_burst.push_back(in_a);
          if (in_last) begin
            r = m_burst[0];
            foreach (m_burst[i]) r = m_acc_or ? (r | m_burst[i]) : (r & m_burst[i]);
            m_valid = 1'b1; m_q = r; m_last = 1'b1;
            m_cnt = (m_burst.size() > CMAX) ? CMAX : m_burst.size();
            m_burst.delete();
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic last, input logic ordy);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_last = last; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] acc;
    logic [7:0] a;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // AND of two operands
    drive(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("and_valid", 32'(out_valid), 32'd1);
    chk("and_q", 32'(out_q), 32'h30);
    chk("and_all", 32'(out_all), 32'd0);
    chk("and_any", 32'(out_any), 32'd1);
    chk("and_count", 32'(out_count), 32'd1);
    tick();

    // Backpressure holds the first result and stalls the second beat
    drive(1'b1, 8'hAA, 8'hFF, 3'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h01, 8'h02, 3'd1, 1'b0, 1'b0);
    chk("bp_q0", 32'(out_q), 32'h55);
    chk("bp_ready0", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold_q", 32'(out_q), 32'h55);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("bp_q1", 32'(out_q), 32'h03);
    chk("bp_valid1", 32'(out_valid), 32'd1);
    tick();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // ACC_AND burst of three
    drive(1'b1, 8'hFF, 8'h00, 3'd6, 1'b0, 1'b1); tick();
    chk("acc_b1", 32'(out_valid), 32'd0);
    drive(1'b1, 8'h0F, 8'h12, 3'd2, 1'b0, 1'b1); tick();
    chk("acc_b2", 32'(out_valid), 32'd0);
    drive(1'b1, 8'h3F, 8'h00, 3'd1, 1'b1, 1'b1); tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("acc_q", 32'(out_q), 32'h0F);
    chk("acc_count", 32'(out_count), 32'd3);
    chk("acc_last", 32'(out_last), 32'd1);
    tick();

    // Single-beat ACC_OR of zero
    drive(1'b1, 8'h00, 8'hFF, 3'd7, 1'b1, 1'b1); tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_q", 32'(out_q), 32'h00);
    chk("one_all", 32'(out_all), 32'd0);
    chk("one_any", 32'(out_any), 32'd0);
    chk("one_count", 32'(out_count), 32'd1);
    tick();

    // 20-beat ACC_OR saturates the count
    acc = 8'h00;
    for (int i = 0; i < 20; i++) begin
      a = 8'(1 << ($urandom % 8)) & 8'(($urandom % 4 == 0) ? 8'hFF : 8'h7F);
      acc = acc | a;
      drive(1'b1, a, 8'(i), 3'd7, (i == 19), 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("sat_q", 32'(out_q), 32'(acc));
    chk("sat_count", 32'(out_count), 32'd15);
    tick();

    // Reset mid-burst discards the partial accumulation
    drive(1'b1, 8'h0F, 8'h00, 3'd6, 1'b0, 1'b1); tick();
    drive(1'b1, 8'h07, 8'h00, 3'd6, 1'b0, 1'b1); tick();
    rst_n = 1'b0;
    drive(1'b1, 8'h03, 8'h00, 3'd6, 1'b1, 1'b1); tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_q", 32'(out_q), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 8'h81, 8'h00, 3'd6, 1'b1, 1'b1); tick();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    chk("fresh_q", 32'(out_q), 32'h81);
    chk("fresh_count", 32'(out_count), 32'd1);
    tick();

    // Randomized traffic, checked by the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom % 150) != 0;
      drive(($urandom % 10) < 7, 8'($urandom), 8'($urandom), 3'($urandom),
            ($urandom % 4) == 0, ($urandom % 10) < 7);
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    tick(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
